// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// int_ctrl_pkg : shared constants, FSM state type and priority helper
// Revision     : 1.0
// ============================================================================
package int_ctrl_pkg;

    localparam int IRQ_N = 8;

    // Byte offsets within the MMIO window; decoded on address bits [3:2].
    localparam logic [3:0] OFF_MASK  = 4'h0;
    localparam logic [3:0] OFF_PEND  = 4'h4;
    localparam logic [3:0] OFF_CAUSE = 4'h8;
    localparam logic [3:0] OFF_CTRL  = 4'hC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    function automatic logic [2:0] prio_idx(input logic [IRQ_N-1:0] act);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (act[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
// int_ctrl_if : CPU data-memory bus as seen by the interrupt controller
// Revision    : 1.0
// ============================================================================
interface int_ctrl_if;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_hit;

    modport master (
        output bus_read, bus_write, bus_addr, bus_wdata,
        input  bus_rdata, bus_hit
    );

    modport slave (
        input  bus_read, bus_write, bus_addr, bus_wdata,
        output bus_rdata, bus_hit
    );
endinterface
`default_nettype wire

// File: rtl/int_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// irq_sync : 2-flop synchronizer plus rising-edge detector for one line
// Revision : 1.0
// ============================================================================
module irq_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic async_in,
    output logic      rise
);
    logic       r_s1, r_s2, r_s3;
    logic [2:0] r_arm;

    // r_arm holds off detection until r_s3 carries a real post-reset sample,
    // so a line already high through reset is never seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_arm <= 3'b000;
        end else begin
            r_s1  <= async_in;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_arm <= {r_arm[1:0], 1'b1};
        end
    end

    assign rise = r_s2 & ~r_s3 & r_arm[2];

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// int_ctrl : 8-line edge-triggered interrupt controller with MMIO registers
// Revision : 1.0
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int          HOLD_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [IRQ_N-1:0] irq_in,
    int_ctrl_if.slave             bus,
    output logic                  interupt,
    output logic [2:0]            irq_id
);
    localparam logic [7:0] c_hold_load = 8'(HOLD_CYCLES - 1);

    logic [IRQ_N-1:0] w_rise;
    logic [IRQ_N-1:0] r_mask, r_pend, w_active;
    logic             r_ctrl_en;
    logic             w_wr;
    logic [3:0]       w_off;
    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [2:0]       r_irq_id, w_id_nxt;
    logic             r_interupt, w_int_nxt;
    logic             w_unused;

    generate
        for (genvar i = 0; i < IRQ_N; i++) begin : g_sync
            irq_sync u_sync (
                .clk      (clk),
                .rst      (rst),
                .async_in (irq_in[i]),
                .rise     (w_rise[i])
            );
        end
    endgenerate

    assign bus.bus_hit = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr        = bus.bus_write & bus.bus_hit;
    assign w_off       = {bus.bus_addr[3:2], 2'b00};
    assign w_unused    = &{1'b0, bus.bus_read, bus.bus_addr[1:0], bus.bus_wdata[31:8]};

    // An edge arriving together with a W1C wins, so the OR comes last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask    <= '0;
            r_pend    <= '0;
            r_ctrl_en <= 1'b0;
        end else begin
            if (w_wr && w_off == OFF_MASK) r_mask    <= bus.bus_wdata[7:0];
            if (w_wr && w_off == OFF_CTRL) r_ctrl_en <= bus.bus_wdata[0];
            if (w_wr && w_off == OFF_PEND) r_pend    <= (r_pend & ~bus.bus_wdata[7:0]) | w_rise;
            else                           r_pend    <= r_pend | w_rise;
        end
    end

    always_comb begin
        bus.bus_rdata = 32'h0;
        if (bus.bus_hit) begin
            case (w_off)
                OFF_MASK:  bus.bus_rdata = {24'h0, r_mask};
                OFF_PEND:  bus.bus_rdata = {24'h0, r_pend};
                OFF_CAUSE: bus.bus_rdata = {28'h0, (r_state != IDLE), r_irq_id};
                OFF_CTRL:  bus.bus_rdata = {31'h0, r_ctrl_en};
                default:   bus.bus_rdata = 32'h0;
            endcase
        end
    end

    assign w_active = r_ctrl_en ? (r_pend & r_mask) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'h0;
            r_irq_id   <= 3'd0;
            r_interupt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_irq_id   <= w_id_nxt;
            r_interupt <= w_int_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_irq_id;
        w_int_nxt   = r_interupt;
        case (r_state)
            IDLE: begin
                if (|w_active) begin
                    w_state_nxt = ASSERT;
                    w_id_nxt    = prio_idx(w_active);
                    w_int_nxt   = 1'b1;
                    w_cnt_nxt   = c_hold_load;
                end
            end
            ASSERT: begin
                if (r_cnt == 8'h0) begin
                    w_state_nxt = WAIT_CLR;
                    w_int_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'h1;
                end
            end
            WAIT_CLR: begin
                if (!r_pend[r_irq_id]) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_int_nxt   = 1'b0;
            end
        endcase
    end

    assign interupt = r_interupt;
    assign irq_id   = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// tb_int_ctrl : directed register table plus multi-cycle interrupt sequences
// Revision    : 1.0
// ============================================================================
module tb_int_ctrl;
    localparam logic [31:0] A_MASK  = 32'h0000_FF00;
    localparam logic [31:0] A_PEND  = 32'h0000_FF04;
    localparam logic [31:0] A_CAUSE = 32'h0000_FF08;
    localparam logic [31:0] A_CTRL  = 32'h0000_FF0C;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          exp_hit;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_in = 8'h0;
    logic       interupt;
    logic [2:0] irq_id;
    int         n_checks = 0;
    int         n_err = 0;
    vec_t       tbl[17];
    logic [31:0] rd;

    int_ctrl_if bus ();

    int_ctrl #(.BASE_ADDR(32'h0000_FF00), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .bus      (bus),
        .interupt (interupt),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.bus_write = 1'b1;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        @(posedge clk);
        #1;
        bus.bus_write = 1'b0;
    endtask

    task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
        bus.bus_addr = a;
        bus.bus_read = 1'b1;
        #1;
        d = bus.bus_rdata;
        bus.bus_read = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input int max, input string name);
        int n = 0;
        while (interupt !== lvl && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'h0, interupt}, {31'h0, lvl});
    endtask

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [31:0] e, bit h);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.exp = e; v.exp_hit = h;
        return v;
    endfunction

    initial begin
        int hi;
        bit seen;
        bus.bus_read = 1'b0; bus.bus_write = 1'b0;
        bus.bus_addr = 32'h0; bus.bus_wdata = 32'h0;

        tbl[0]  = mk(0, A_MASK,  0, 32'h0, 1);
        tbl[1]  = mk(0, A_PEND,  0, 32'h0, 1);
        tbl[2]  = mk(0, A_CAUSE, 0, 32'h0, 1);
        tbl[3]  = mk(0, A_CTRL,  0, 32'h0, 1);
        tbl[4]  = mk(1, A_MASK,  32'h0000_00A5, 0, 1);
        tbl[5]  = mk(0, A_MASK,  0, 32'hA5, 1);
        tbl[6]  = mk(0, 32'h0000_FF03, 0, 32'hA5, 1);
        tbl[7]  = mk(1, A_CTRL,  32'hFFFF_FFFE, 0, 1);
        tbl[8]  = mk(0, A_CTRL,  0, 32'h0, 1);
        tbl[9]  = mk(1, 32'h0000_FF10, 32'hFFFF_FFFF, 0, 0);
        tbl[10] = mk(0, 32'h0000_FF10, 0, 32'h0, 0);
        tbl[11] = mk(0, 32'h0001_FF00, 0, 32'h0, 0);
        tbl[12] = mk(0, A_MASK,  0, 32'hA5, 1);
        tbl[13] = mk(1, A_MASK,  32'h0000_01FF, 0, 1);
        tbl[14] = mk(0, A_MASK,  0, 32'hFF, 1);
        tbl[15] = mk(1, A_CAUSE, 32'h0000_000F, 0, 1);
        tbl[16] = mk(0, A_CAUSE, 0, 32'h0, 1);

        tick(2);
        check("reset_interupt", {31'h0, interupt}, 32'h0);
        check("reset_irq_id", {29'h0, irq_id}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                bus_wr(tbl[i].addr, tbl[i].data);
            end else begin
                @(negedge clk);
                rd_now(tbl[i].addr, rd);
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
                check($sformatf("tbl%0d_hit", i), {31'h0, bus.bus_hit}, {31'h0, tbl[i].exp_hit});
            end
        end

        // Single request: latency, hold length, CAUSE, held line sets PEND once.
        bus_wr(A_MASK, 32'h01);
        bus_wr(A_CTRL, 32'h01);
        @(negedge clk);
        irq_in[0] = 1'b1;
        tick(1); rd_now(A_PEND, rd); check("lat_e1_pend", rd, 32'h0);
        tick(1); rd_now(A_PEND, rd); check("lat_e2_pend", rd, 32'h0);
        tick(1); rd_now(A_PEND, rd); check("lat_e3_pend", rd, 32'h01);
        check("lat_e3_int", {31'h0, interupt}, 32'h0);
        tick(1);
        check("lat_e4_int", {31'h0, interupt}, 32'h1);
        check("lat_e4_id", {29'h0, irq_id}, 32'h0);
        rd_now(A_CAUSE, rd); check("lat_cause", rd, 32'h8);
        hi = 1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (interupt) hi++;
            else break;
        end
        check("hold_cycles", hi, 4);
        rd_now(A_CAUSE, rd); check("waitclr_cause", rd, 32'h8);
        bus_wr(A_PEND, 32'h01);
        tick(3);
        rd_now(A_PEND, rd); check("held_once_pend", rd, 32'h0);
        rd_now(A_CAUSE, rd); check("idle_cause", rd, 32'h0);
        check("idle_int", {31'h0, interupt}, 32'h0);
        irq_in[0] = 1'b0;
        tick(4);

        // Two simultaneous requests: lowest index first, then the other.
        bus_wr(A_MASK, 32'hFF);
        @(negedge clk);
        irq_in = 8'h24;
        wait_level(1'b1, 10, "prio_int_up");
        check("prio_id2", {29'h0, irq_id}, 32'd2);
        wait_level(1'b0, 10, "prio_int_down");
        bus_wr(A_PEND, 32'h04);
        check("w1c_int_low", {31'h0, interupt}, 32'h0);
        tick(1);
        rd_now(A_CAUSE, rd); check("w1c_idle_cause", rd, 32'h2);
        check("w1c_idle_int", {31'h0, interupt}, 32'h0);
        tick(1);
        check("second_int", {31'h0, interupt}, 32'h1);
        check("second_id5", {29'h0, irq_id}, 32'd5);
        wait_level(1'b0, 10, "second_down");
        bus_wr(A_PEND, 32'h20);
        irq_in = 8'h0;
        tick(4);

        // Masked request stays pending until unmasked.
        bus_wr(A_MASK, 32'h00);
        @(negedge clk);
        irq_in[3] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (interupt) seen = 1'b1;
        end
        check("masked_no_int", {31'h0, seen}, 32'h0);
        rd_now(A_PEND, rd); check("masked_pend", rd, 32'h08);
        irq_in[3] = 1'b0;
        bus_wr(A_MASK, 32'h08);
        for (int k = 0; k < 2; k++) begin
            if (interupt) break;
            tick(1);
        end
        check("unmask_int", {31'h0, interupt}, 32'h1);
        check("unmask_id3", {29'h0, irq_id}, 32'd3);
        wait_level(1'b0, 10, "unmask_down");
        bus_wr(A_PEND, 32'h08);
        tick(3);

        // W1C coinciding with a fresh edge on the same bit.
        bus_wr(A_MASK, 32'h00);
        @(negedge clk);
        irq_in[1] = 1'b1;
        tick(4);
        irq_in[1] = 1'b0;
        tick(4);
        rd_now(A_PEND, rd); check("race_pre_pend", rd, 32'h02);
        @(negedge clk);
        irq_in[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        bus_wr(A_PEND, 32'h02);
        rd_now(A_PEND, rd); check("race_pend_kept", rd, 32'h02);
        bus_wr(A_PEND, 32'h02);
        rd_now(A_PEND, rd); check("plain_w1c", rd, 32'h0);
        irq_in[1] = 1'b0;
        tick(4);

        // Reset in the middle of ASSERT with lines held high across it.
        bus_wr(A_MASK, 32'h01);
        bus_wr(A_CTRL, 32'h01);
        @(negedge clk);
        irq_in = 8'hC1;
        wait_level(1'b1, 10, "rst_int_up");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_int", {31'h0, interupt}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        rd_now(A_MASK, rd);  check("post_rst_mask", rd, 32'h0);
        rd_now(A_PEND, rd);  check("post_rst_pend", rd, 32'h0);
        rd_now(A_CAUSE, rd); check("post_rst_cause", rd, 32'h0);
        rd_now(A_CTRL, rd);  check("post_rst_ctrl", rd, 32'h0);
        check("post_rst_int", {31'h0, interupt}, 32'h0);
        irq_in = 8'h0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_FF00: word-aligned base of the 4-register MMIO window.
REQ-002 Parameter HOLD_CYCLES, default 4, legal range 1..255: number of cycles `interupt` stays high per request.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port irq_in, input, 8 bits: asynchronous external request lines; a rising edge raises the request.
REQ-006 Port bus_read, input, 1 bit: the CPU data-memory read strobe.
REQ-007 Port bus_write, input, 1 bit: the CPU data-memory write strobe.
REQ-008 Port bus_addr, input, 32 bits: the CPU data-memory address.
REQ-009 Port bus_wdata, input, 32 bits: the CPU data-memory write data.
REQ-010 Port bus_rdata, output, 32 bits: read data, combinational.
REQ-011 Port bus_hit, output, 1 bit: bus_addr[31:4] matches BASE_ADDR[31:4].
REQ-012 Port interupt, output, 1 bit: registered output that freezes the CPU program counter while high.
REQ-013 Port irq_id, output, 3 bits: registered index of the request being served.

Function
REQ-014 Each irq_in bit passes through a 2-flop synchronizer and then a rising-edge detector (sync2 & ~sync3).
REQ-015 Registers sit at offsets from BASE_ADDR and are decoded on bus_addr[3:2], ignoring bus_addr[1:0]:
- 0x0 MASK, 8-bit, read/write.
- 0x4 PEND, read; write-1-to-clear.
- 0x8 CAUSE, read-only: {valid, id[2:0]}.
- 0xC CTRL, read/write: bit0 is the global enable.
REQ-016 A detected edge sets its PEND bit at the next clock edge; an irq_in held high sets PEND only once.
REQ-017 A simultaneous edge-set and W1C on the same PEND bit leaves the bit set.
REQ-018 Active = PEND & MASK, gated by CTRL[0]; the lowest set index has highest priority.
REQ-019 The FSM has three states: IDLE, ASSERT and WAIT_CLR.
REQ-020 IDLE -> ASSERT when Active != 0: latch irq_id = the priority index, set interupt=1, load counter = HOLD_CYCLES-1.
REQ-021 ASSERT: decrement the counter each cycle; at 0 go to WAIT_CLR and drop interupt. interupt is therefore high for exactly HOLD_CYCLES cycles.
REQ-022 WAIT_CLR: stay until PEND[irq_id] is 0, then return to IDLE. A new Active request re-enters ASSERT no earlier than the cycle after IDLE.
REQ-023 Writes to MASK or CTRL during ASSERT or WAIT_CLR do not abort the FSM; they only affect the next selection.
REQ-024 Latency: irq_in rises before clock edge 1 -> PEND set at edge 3 -> interupt high after edge 4 (MASK and enable already set).
REQ-025 Reads with bus_hit=1 return the register zero-extended to 32 bits. With bus_hit=0, bus_rdata=0 and writes are ignored.
REQ-026 Register writes take effect at the clock edge where bus_write=1 and bus_hit=1.
REQ-027 bus_read has no side effects.
REQ-028 CAUSE.valid=1 iff the state is not IDLE; CAUSE.id = irq_id.

Reset
REQ-029 While rst is high, all of the following are 0: synchronizers, PEND, MASK, CTRL, counter, irq_id and interupt; the FSM is in IDLE.
REQ-030 Reset asserted mid-ASSERT drops interupt within the same cycle (asynchronously); requests in flight are lost.
REQ-031 After rst deasserts, no edge is detected for an irq_in that was already high throughout reset.

Structure
REQ-032 A shared package int_ctrl_pkg holds:
- the register offset constants (MASK/PEND/CAUSE/CTRL);
- the FSM state enum (IDLE/ASSERT/WAIT_CLR);
- the IRQ count constant 8.
REQ-033 One sub-module, irq_sync, implements the per-line 2-flop synchronizer plus edge detector and is instantiated 8 times (generate loop).

Verification
REQ-034 MASK=0x01, CTRL=1, pulse irq_in[0] -> PEND=0x01 at edge 3; interupt high for exactly 4 cycles starting after edge 4; irq_id=0; CAUSE reads 0x8.
REQ-035 irq_in[5] and irq_in[2] rise together with MASK=0xFF -> irq_id=2. After W1C 0x04 to PEND, IDLE then ASSERT with irq_id=5.
REQ-036 MASK=0x00, pulse irq_in[3] -> PEND=0x08 and interupt stays 0. Then writing MASK=0x08 -> interupt rises within 2 cycles.
REQ-037 W1C of bit 1 in the same cycle that a new irq_in[1] edge is detected -> PEND[1] remains 1.
REQ-038 Assert rst during cycle 2 of ASSERT -> interupt=0 immediately; all registers read 0 after release; held-high irq_in lines produce no PEND bit.
REQ-039 Read at 0x0000_FF10 (outside the window) -> bus_hit=0, bus_rdata=0; a write there leaves all registers unchanged.
